// File: rtl/load_store_unit_if.sv
// Core-side and memory-side signal bundle of the load/store unit.
// The slave modport is the unit's own view; master is the core/memory environment.
interface load_store_unit_if;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        bus_err_o;
   logic        misalign_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   modport slave (
      input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
      input  mem_rd_i, mem_ready_i,
      output core_rd_o, core_stall_o, bus_err_o, misalign_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
   );

   modport master (
      output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
      output mem_rd_i, mem_ready_i,
      input  core_rd_o, core_stall_o, bus_err_o, misalign_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> WAIT -> DONE memory handshake with byte lanes, load extension
// and bounded wait. Optional macro LSU_MISALIGN_CHECK_EN blocks misaligned H/W accesses.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   load_store_unit_if.slave   bus
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [2:0]         size_r;
   logic [1:0]         off_r;
   logic               we_r;
   logic [31:0]        rd_r;
   logic               bus_err_r;
   logic               misalign_s;
   logic               issue_s;
   logic               timeout_s;
   logic               mem_req_s;
   logic               mem_we_s;
   logic               stall_s;
   logic [3:0]         be_s;
   logic [31:0]        wd_s;
   logic [31:0]        rd_ext_s;
   logic [7:0]         byte_s;
   logic [15:0]        half_s;

   // 0 = byte, 1 = half, 2 = word; unknown codes behave as word
   function automatic logic [1:0] size_class(input logic [2:0] size);
      case (size)
         3'd0, 3'd4: size_class = 2'd0;
         3'd1, 3'd5: size_class = 2'd1;
         default:    size_class = 2'd2;
      endcase
   endfunction

`ifdef LSU_MISALIGN_CHECK_EN
   // Flag misaligned half/word requests at issue time
   always_comb begin
      misalign_s = 1'b0;
      if (!rst_i && state_r == ST_IDLE && bus.core_req_i) begin
         case (size_class(bus.core_size_i))
            2'd1:    misalign_s = bus.core_addr_i[0];
            2'd2:    misalign_s = (bus.core_addr_i[1:0] != 2'b00);
            default: misalign_s = 1'b0;
         endcase
      end else begin
         misalign_s = 1'b0;
      end
   end
`else
   assign misalign_s = 1'b0;
`endif

   assign issue_s   = (state_r == ST_IDLE) && bus.core_req_i && !misalign_s;
   assign timeout_s = (TIMEOUT_CYCLES != 0) && (int'(cnt_r) == TIMEOUT_CYCLES - 1);

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: state_next_s = issue_s ? ST_WAIT : ST_IDLE;
         ST_WAIT: state_next_s = (bus.mem_ready_i || timeout_s) ? ST_DONE : ST_WAIT;
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM outputs; reset forces the request and stall low in the same cycle
   always_comb begin
      mem_req_s = 1'b0;
      mem_we_s  = 1'b0;
      stall_s   = 1'b0;
      if (rst_i) begin
         mem_req_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               mem_req_s = issue_s;
               mem_we_s  = issue_s && bus.core_we_i;
               stall_s   = issue_s;
            end
            ST_WAIT: begin
               mem_req_s = 1'b1;
               mem_we_s  = we_r;
               stall_s   = 1'b1;
            end
            default: mem_req_s = 1'b0;
         endcase
      end
   end

   // Counter, request capture, load result and error pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_r     <= '0;
         size_r    <= 3'd0;
         off_r     <= 2'd0;
         we_r      <= 1'b0;
         rd_r      <= 32'd0;
         bus_err_r <= 1'b0;
      end else begin
         bus_err_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               cnt_r <= '0;
               if (issue_s) begin
                  size_r <= bus.core_size_i;
                  off_r  <= bus.core_addr_i[1:0];
                  we_r   <= bus.core_we_i;
               end
            end
            ST_WAIT: begin
               cnt_r <= cnt_r + 1'b1;
               if (bus.mem_ready_i) begin
                  rd_r <= we_r ? 32'd0 : rd_ext_s;
               end else if (timeout_s) begin
                  rd_r      <= 32'd0;
                  bus_err_r <= 1'b1;
               end
            end
            default: cnt_r <= '0;
         endcase
      end
   end

   // Byte enables and lane-replicated store data from the live core request
   always_comb begin
      be_s = 4'b1111;
      wd_s = bus.core_wd_i;
      case (size_class(bus.core_size_i))
         2'd0: begin
            be_s = 4'b0001 << bus.core_addr_i[1:0];
            wd_s = {4{bus.core_wd_i[7:0]}};
         end
         2'd1: begin
            be_s = 4'b0011 << {bus.core_addr_i[1], 1'b0};
            wd_s = {2{bus.core_wd_i[15:0]}};
         end
         default: begin
            be_s = 4'b1111;
            wd_s = bus.core_wd_i;
         end
      endcase
   end

   // Load extraction uses the offset captured at issue
   assign byte_s = bus.mem_rd_i[8*off_r +: 8];
   assign half_s = off_r[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];

   always_comb begin
      case (size_r)
         3'd0:    rd_ext_s = {{24{byte_s[7]}}, byte_s};
         3'd4:    rd_ext_s = {24'd0, byte_s};
         3'd1:    rd_ext_s = {{16{half_s[15]}}, half_s};
         3'd5:    rd_ext_s = {16'd0, half_s};
         default: rd_ext_s = bus.mem_rd_i;
      endcase
   end

   assign bus.mem_req_o    = mem_req_s;
   assign bus.mem_we_o     = mem_we_s;
   assign bus.core_stall_o = stall_s;
   assign bus.mem_be_o     = mem_req_s ? be_s : 4'b0000;
   assign bus.mem_wd_o     = mem_req_s ? wd_s : 32'd0;
   assign bus.mem_addr_o   = mem_req_s ? bus.core_addr_i : 32'd0;
   assign bus.core_rd_o    = rd_r;
   assign bus.bus_err_o    = bus_err_r;
   assign bus.misalign_o   = misalign_s;
endmodule
